// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: handshake, status and serial-line bundle for uart_tx_frame.
interface uart_tx_frame_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          tx_valid_i;
    logic [DATA_BITS-1:0]          tx_data_i;
    logic                          tx_ready_o;
    logic                          tx_busy_o;
    logic                          tx_done_o;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_o;
    logic                          u_tx_o;

    modport master (
        output tx_valid_i, tx_data_i,
        input  tx_ready_o, tx_busy_o, tx_done_o, fifo_level_o, u_tx_o
    );

    modport slave (
        input  tx_valid_i, tx_data_i,
        output tx_ready_o, tx_busy_o, tx_done_o, fifo_level_o, u_tx_o
    );
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter fed by a small FIFO, sending frames back-to-back.
module uart_tx_frame #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 1,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input logic            clk_i,
    input logic            rst_i,
    uart_tx_frame_if.slave bus
);
    localparam int BPS_DR = CLK_FREQ_HZ / BAUD;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = $clog2(STOP_BITS * BPS_DR);
    localparam int BW     = $clog2(DATA_BITS);

    generate
        if (BPS_DR < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("uart_tx_frame: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          level;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_n;
    logic [DATA_BITS-1:0] sh, sh_n, head;
    logic                 par, par_n, tx, tx_n, busy;
    logic                 push, pop, empty, last, stop_last, head_par;

    assign empty     = level == '0;
    assign push      = bus.tx_valid_i && bus.tx_ready_o;
    assign head      = mem[rd_ptr];
    assign head_par  = PARITY == 1 ? ~^head : ^head;
    assign last      = cnt == CW'(BPS_DR - 1);
    assign stop_last = cnt == CW'(STOP_BITS * BPS_DR - 1);

    assign bus.tx_ready_o   = level < (AW + 1)'(FIFO_DEPTH);
    assign bus.tx_done_o    = state == STOP && stop_last;
    assign bus.tx_busy_o    = busy;
    assign bus.fifo_level_o = level;
    assign bus.u_tx_o       = tx;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        sh_n    = sh;
        par_n   = par;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                pop   = !empty;
            end
            START: if (last) begin
                cnt_n   = '0;
                state_n = DATA;
                tx_n    = sh[0];
                bit_n   = '0;
            end
            DATA: if (last) begin
                cnt_n = '0;
                bit_n = bit_idx + 1'b1;
                sh_n  = sh >> 1;
                tx_n  = sh[1];
                if (bit_idx == BW'(DATA_BITS - 1)) begin
                    state_n = PARITY != 0 ? PAR : STOP;
                    tx_n    = PARITY != 0 ? par : 1'b1;
                end
            end
            PAR: if (last) begin
                cnt_n   = '0;
                state_n = STOP;
                tx_n    = 1'b1;
            end
            STOP: if (stop_last) begin
                cnt_n   = '0;
                state_n = IDLE;
                pop     = !empty;
            end
            default: state_n = IDLE;
        endcase
        // a pop always starts a new frame, whether from IDLE or straight out of STOP
        if (pop) begin
            state_n = START;
            sh_n    = head;
            par_n   = head_par;
            tx_n    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            sh      <= sh_n;
            par     <= par_n;
            tx      <= tx_n;
            busy    <= state_n != IDLE || !empty;
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            level   <= level + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= bus.tx_data_i;
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench for three uart_tx_frame configurations at 10 clocks per bit.
module tb_uart_tx_frame;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cmp = 0;
    int fail = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) i0 ();
    uart_tx_frame_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) i1 ();
    uart_tx_frame_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) i2 ();

    uart_tx_frame #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (.clk_i(clk), .rst_i(rst), .bus(i0));
    uart_tx_frame #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (.clk_i(clk), .rst_i(rst), .bus(i1));
    uart_tx_frame #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (.clk_i(clk), .rst_i(rst), .bus(i2));

    function automatic logic line(input int which);
        return which == 0 ? i0.u_tx_o : which == 1 ? i1.u_tx_o : i2.u_tx_o;
    endfunction

    function automatic logic done(input int which);
        return which == 0 ? i0.tx_done_o : which == 1 ? i1.tx_done_o : i2.tx_done_o;
    endfunction

    function automatic logic busy(input int which);
        return which == 0 ? i0.tx_busy_o : which == 1 ? i1.tx_busy_o : i2.tx_busy_o;
    endfunction

    task automatic drive(input int which, input logic v, input logic [8:0] w);
        if (which == 0) begin
            i0.tx_valid_i = v;
            i0.tx_data_i  = w[7:0];
        end else if (which == 1) begin
            i1.tx_valid_i = v;
            i1.tx_data_i  = w[6:0];
        end else begin
            i2.tx_valid_i = v;
            i2.tx_data_i  = w[7:0];
        end
    endtask

    // Called at a negedge; waits for a start bit, then checks every cycle of the frame
    // against the word at the head of the scoreboard. Returns one negedge past the frame.
    task automatic capture(input int which, input int nbits, input int par, input int nstop,
                           input int exp_gap, input string name);
        logic [8:0] w;
        logic [15:0] ev, av, bad;
        logic p, eb, s;
        int t, n, b, bad_done, bad_busy;
        t = 0;
        while (line(which) !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        cmp++;
        if (t != exp_gap) begin
            fail++;
            $display("FAIL %s start_gap actual %0d required %0d", name, t, exp_gap);
        end
        if (t >= 400) return;
        cmp++;
        if (sb.size() == 0) begin
            fail++;
            $display("FAIL %s scoreboard actual empty required word", name);
            return;
        end
        w = sb.pop_front();
        p = 1'b0;
        for (int j = 0; j < nbits; j++) p ^= w[j];
        if (par == 1) p = ~p;
        n = (1 + nbits + (par != 0 ? 1 : 0) + nstop) * 10;
        ev = '0; av = '0; bad = '0; bad_done = 0; bad_busy = 0;
        for (int c = 0; c < n; c++) begin
            b = c / 10;
            eb = b == 0 ? 1'b0 : b <= nbits ? w[b-1] : (par != 0 && b == nbits + 1) ? p : 1'b1;
            ev[b] = eb;
            s = line(which);
            if (c % 10 == 5 && !bad[b]) av[b] = s;
            if (s !== eb && !bad[b]) begin
                bad[b] = 1'b1;
                av[b]  = s;
            end
            if (done(which) !== (c == n - 1)) bad_done++;
            if (busy(which) !== 1'b1) bad_busy++;
            @(negedge clk);
        end
        for (int j = 0; j < n / 10; j++) begin
            cmp++;
            if (bad[j]) begin
                fail++;
                $display("FAIL %s line_bit%0d actual %b required %b (word %h)", name, j, av[j], ev[j], w);
            end
        end
        cmp++;
        if (bad_done != 0) begin
            fail++;
            $display("FAIL %s done_pulse actual %0d wrong cycles required 0", name, bad_done);
        end
        cmp++;
        if (bad_busy != 0) begin
            fail++;
            $display("FAIL %s busy_in_frame actual %0d low cycles required 0", name, bad_busy);
        end
    endtask

    task automatic offer(input logic [7:0] w, inout int full_seen, inout int bad_lvl);
        logic r;
        int t = 0;
        drive(0, 1'b1, {1'b0, w});
        do begin
            r = i0.tx_ready_o;
            if (!r) begin
                full_seen = 1;
                if (i0.fifo_level_o !== 3'd4) bad_lvl++;
            end
            @(negedge clk);
            t++;
        end while (!r && t < 400);
        cmp++;
        if (!r) begin
            fail++;
            $display("FAIL offer_timeout actual ready 0 required 1");
        end else sb.push_back({1'b0, w});
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        cmp += 5;
        if (i0.u_tx_o !== 1'b1) begin fail++; $display("FAIL rst_line actual %b required 1", i0.u_tx_o); end
        if (i0.tx_ready_o !== 1'b1) begin fail++; $display("FAIL rst_ready actual %b required 1", i0.tx_ready_o); end
        if (i0.tx_busy_o !== 1'b0) begin fail++; $display("FAIL rst_busy actual %b required 0", i0.tx_busy_o); end
        if (i0.tx_done_o !== 1'b0) begin fail++; $display("FAIL rst_done actual %b required 0", i0.tx_done_o); end
        if (i0.fifo_level_o !== 3'd0) begin fail++; $display("FAIL rst_level actual %0d required 0", i0.fifo_level_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_odd_parity;
        drive(0, 1'b1, 9'h055);
        sb.push_back(9'h055);
        @(negedge clk);
        drive(0, 1'b0, 9'h0);
        capture(0, 8, 1, 1, 1, "odd55");
        cmp += 2;
        if (i0.tx_busy_o !== 1'b0) begin fail++; $display("FAIL odd55_busy_after actual %b required 0", i0.tx_busy_o); end
        if (i0.fifo_level_o !== 3'd0) begin fail++; $display("FAIL odd55_level_after actual %0d required 0", i0.fifo_level_o); end
    endtask

    task automatic test_even_two_stop;
        drive(1, 1'b1, 9'h00B);
        sb.push_back(9'h00B);
        @(negedge clk);
        drive(1, 1'b0, 9'h0);
        capture(1, 7, 2, 2, 1, "even0B");
    endtask

    task automatic test_no_parity;
        drive(2, 1'b1, 9'h0A5);
        sb.push_back(9'h0A5);
        @(negedge clk);
        drive(2, 1'b0, 9'h0);
        capture(2, 8, 0, 1, 1, "noneA5");
    endtask

    task automatic test_back_to_back;
        int fs = 0, bl = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) offer(8'h0F + 8'(i * 17), fs, bl);
                drive(0, 1'b0, 9'h0);
            end
            begin
                @(negedge clk);
                capture(0, 8, 1, 1, 1, "b2b_first");
                for (int i = 1; i < 6; i++) capture(0, 8, 1, 1, 0, "b2b_next");
            end
        join
        cmp += 2;
        if (fs != 1) begin fail++; $display("FAIL b2b_ready_fell actual %0d required 1", fs); end
        if (bl != 0) begin fail++; $display("FAIL b2b_level_when_not_ready actual %0d bad required 0", bl); end
    endtask

    task automatic test_overflow;
        int fs = 0, bl = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) offer(8'hA0 + 8'(i * 3), fs, bl);
                drive(0, 1'b1, 9'h0C3);
                for (int i = 0; i < 15; i++) begin
                    cmp++;
                    if (i0.fifo_level_o !== 3'd4) begin
                        fail++;
                        $display("FAIL ovf_level actual %0d required 4", i0.fifo_level_o);
                    end
                    @(negedge clk);
                end
                drive(0, 1'b0, 9'h0);
                repeat (5) @(negedge clk);
                offer(8'hC3, fs, bl);
                drive(0, 1'b0, 9'h0);
            end
            begin
                @(negedge clk);
                capture(0, 8, 1, 1, 1, "ovf_first");
                for (int i = 1; i < 6; i++) capture(0, 8, 1, 1, 0, "ovf_next");
            end
        join
        cmp++;
        if (bl != 0) begin fail++; $display("FAIL ovf_level_when_not_ready actual %0d bad required 0", bl); end
    endtask

    task automatic test_reset_mid_frame;
        int fs = 0, bl = 0, bad_done = 0, bad_line = 0;
        offer(8'h81, fs, bl);
        offer(8'h42, fs, bl);
        offer(8'h24, fs, bl);
        drive(0, 1'b0, 9'h0);
        repeat (44) @(negedge clk);
        cmp += 2;
        if (i0.u_tx_o !== 1'b0) begin fail++; $display("FAIL mid_bit3_line actual %b required 0", i0.u_tx_o); end
        if (i0.fifo_level_o !== 3'd2) begin fail++; $display("FAIL mid_level actual %0d required 2", i0.fifo_level_o); end
        rst = 1'b1;
        #1;
        cmp += 5;
        if (i0.u_tx_o !== 1'b1) begin fail++; $display("FAIL arst_line actual %b required 1", i0.u_tx_o); end
        if (i0.fifo_level_o !== 3'd0) begin fail++; $display("FAIL arst_level actual %0d required 0", i0.fifo_level_o); end
        if (i0.tx_ready_o !== 1'b1) begin fail++; $display("FAIL arst_ready actual %b required 1", i0.tx_ready_o); end
        if (i0.tx_busy_o !== 1'b0) begin fail++; $display("FAIL arst_busy actual %b required 0", i0.tx_busy_o); end
        if (i0.tx_done_o !== 1'b0) begin fail++; $display("FAIL arst_done actual %b required 0", i0.tx_done_o); end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i0.tx_done_o !== 1'b0) bad_done++;
            if (i0.u_tx_o !== 1'b1) bad_line++;
            @(negedge clk);
        end
        cmp += 2;
        if (bad_done != 0) begin fail++; $display("FAIL post_rst_done actual %0d pulses required 0", bad_done); end
        if (bad_line != 0) begin fail++; $display("FAIL post_rst_idle actual %0d low cycles required 0", bad_line); end
        drive(0, 1'b1, 9'h03C);
        sb.push_back(9'h03C);
        @(negedge clk);
        drive(0, 1'b0, 9'h0);
        capture(0, 8, 1, 1, 1, "post_rst3C");
    endtask

    initial begin
        drive(0, 1'b0, 9'h0);
        drive(1, 1'b0, 9'h0);
        drive(2, 1'b0, 9'h0);
        test_reset;
        test_odd_parity;
        test_even_two_stop;
        test_no_parity;
        test_back_to_back;
        test_overflow;
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end
endmodule
